bram_stream_reader: RTL and testbench



---
 rtl/rz_bram_pkg.sv | 13 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/bram_stream_reader.sv | 157 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rz_bram_pkg.sv
// Shared definitions for the block-RAM stream reader and its matching writer.
package rz_bram_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO whose head word sits in a register that drives the outputs.
module sync_fifo
    import rz_bram_pkg::*;
#(
    parameter int unsigned W = 64
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic [W-1:0]       dout,
    output logic               valid,
    output logic [FIFO_CW-1:0] count
);

    // Head register plus a backing store for the remaining entries.
    localparam int unsigned BK = FIFO_DEPTH - 1;
    localparam int unsigned PW = $clog2(BK);

    logic [W-1:0]       mem [BK];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [FIFO_CW-1:0] bk_cnt;
    logic               take_head;
    logic               load_head;
    logic               bk_pop;
    logic               bk_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BK - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        bk_cnt    = count - FIFO_CW'(valid);
        take_head = valid & pop;
        load_head = ~valid | take_head;
        bk_pop    = load_head & (bk_cnt != '0);
        bk_push   = push & ~(load_head & (bk_cnt == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout   <= '0;
            valid  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Refill the head from the backing store first, else bypass the incoming word.
            if (load_head) begin
                if (bk_cnt != '0) begin
                    dout  <= mem[rd_ptr];
                    valid <= 1'b1;
                end else if (push) begin
                    dout  <= din;
                    valid <= 1'b1;
                end else begin
                    dout  <= '0;
                    valid <= 1'b0;
                end
            end
            if (bk_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (bk_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + FIFO_CW'(push) - FIFO_CW'(take_head);
        end
    end

    always_ff @(posedge clk) begin
        if (bk_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Drains a circular region of the block RAM onto a valid/ready stream,
// absorbing the RAM's one-cycle read latency with a credit-limited FIFO.
module bram_stream_reader
    import rz_bram_pkg::*;
#(
    parameter  int unsigned DW    = 64,
    parameter  int unsigned DEPTH = 2880,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int unsigned OW = FIFO_CW + 1;

    rd_state_e          state;
    rd_state_e          state_n;
    logic               busy_n;
    logic               done_n;
    logic               ram_re_n;
    logic [AW-1:0]      ram_ra_n;
    logic               re_last;
    logic               re_last_n;
    logic [LW-1:0]      issue_cnt;
    logic [LW-1:0]      issue_n;
    logic [LW-1:0]      deliv_cnt;
    logic [LW-1:0]      deliv_n;
    logic               inflight;
    logic               inflight_last;
    logic [FIFO_CW-1:0] fifo_count;
    logic [DW:0]        fifo_dout;
    logic [OW-1:0]      outstanding;
    logic               credit_ok;
    logic               handshake;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // Words in the FIFO, in the RAM pipeline and being issued right now; pops are
    // deliberately ignored so out_ready never reaches the read enable.
    always_comb begin
        outstanding = OW'(fifo_count) + OW'(inflight) + OW'(ram_re);
        credit_ok   = outstanding < OW'(FIFO_DEPTH);
        handshake   = out_valid & out_ready;
    end

    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        ram_re_n  = 1'b0;
        re_last_n = 1'b0;
        ram_ra_n  = ram_ra;
        issue_n   = issue_cnt;
        deliv_n   = deliv_cnt - LW'(handshake);
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_n   = READ;
                        ram_re_n  = 1'b1;
                        ram_ra_n  = start_addr;
                        issue_n   = len - 1'b1;
                        deliv_n   = len;
                        re_last_n = (len == LW'(1));
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            READ: begin
                // issue_cnt counts reads still to be issued after the one on ram_re now.
                if (issue_cnt == '0) begin
                    state_n = DRAIN;
                end else if (credit_ok) begin
                    ram_re_n  = 1'b1;
                    ram_ra_n  = addr_inc(ram_ra);
                    issue_n   = issue_cnt - 1'b1;
                    re_last_n = (issue_cnt == LW'(1));
                end
            end
            DRAIN: begin
                if ((deliv_cnt == '0) || (handshake && (deliv_cnt == LW'(1)))) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_re        <= 1'b0;
            ram_ra        <= '0;
            re_last       <= 1'b0;
            issue_cnt     <= '0;
            deliv_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_n;
            busy          <= busy_n;
            done          <= done_n;
            ram_re        <= ram_re_n;
            ram_ra        <= ram_ra_n;
            re_last       <= re_last_n;
            issue_cnt     <= issue_n;
            deliv_cnt     <= deliv_n;
            inflight      <= ram_re;
            inflight_last <= re_last;
        end
    end

    // The final-word flag travels with its data so out_last comes straight from a register.
    sync_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   ({inflight_last, ram_rd}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .valid (out_valid),
        .count (fifo_count)
    );

    assign out_data = fifo_dout[DW-1:0];
    assign out_last = fifo_dout[DW];

    ap_start_addr: assert property (@(posedge clk) disable iff (reset)
        (start && !busy) |-> (32'(start_addr) < DEPTH));

    ap_len: assert property (@(posedge clk) disable iff (reset)
        (start && !busy) |-> (32'(len) <= DEPTH));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized and directed bench for bram_stream_reader against a queue-based stream model.
module tb_bram_stream_reader;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 2880;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    typedef logic [DW+1:0] cv_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    bram_stream_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_ra     (ram_ra),
        .ram_re     (ram_re),
        .ram_rd     (ram_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] exp_ra_q[$];

    int   re_cnt, hs_cnt, done_cnt;
    int   first_re_cyc, first_valid_cyc, first_busy_cyc, last_hs_cyc, done_cyc;
    bit   valid_seen;
    bit   prev_stall;
    logic [DW:0] prev_word;
    int   ready_mode;
    int   t0, base;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM read port with one cycle of registered latency.
    always @(posedge clk) if (ram_re) ram_rd <= mem[ram_ra];

    task automatic check(input string tag, input cv_t got, input cv_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Backpressure driver: 0 = stalled, 1 = always ready, otherwise random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream monitor and scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            logic [DW:0] w;
            if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
            if (ram_re) begin
                if (re_cnt == 0) first_re_cyc = cyc;
                re_cnt++;
                if (exp_ra_q.size() == 0) check("extra_re", cv_t'(1), cv_t'(0));
                else check("ram_ra", cv_t'(ram_ra), cv_t'(exp_ra_q.pop_front()));
                check("outstanding_le4", cv_t'(re_cnt - hs_cnt > 4), cv_t'(0));
            end
            if (out_valid && !valid_seen) begin
                first_valid_cyc = cyc;
                valid_seen = 1'b1;
            end
            if (prev_stall)
                check("stall_hold", cv_t'({out_valid, out_last, out_data}), cv_t'({1'b1, prev_word}));
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) check("extra_word", cv_t'(1), cv_t'(0));
                else begin
                    w = exp_q.pop_front();
                    check("data", cv_t'(out_data), cv_t'(w[DW-1:0]));
                    check("last", cv_t'(out_last), cv_t'(w[DW]));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", cv_t'(busy), cv_t'(0));
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Loads the expected stream for a transfer and pulses start.
    task automatic launch(input int addr, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (addr + k) % DEPTH;
            exp_ra_q.push_back(AW'(a));
            exp_q.push_back({1'(k == n - 1), mem[a]});
        end
        re_cnt = 0; hs_cnt = 0; valid_seen = 1'b0;
        first_re_cyc = -1; first_valid_cyc = -1; first_busy_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1;
        base = done_cnt;
        t0 = cyc;
        start = 1'b1;
        start_addr = AW'(addr);
        len = LW'(n);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done_cnt == base && i < budget) begin
            tick(1);
            i++;
        end
        check("done_timeout", cv_t'(done_cnt == base), cv_t'(0));
        tick(2);
    endtask

    task automatic post_checks();
        check("leftover_words", cv_t'(exp_q.size()), cv_t'(0));
        check("leftover_reads", cv_t'(exp_ra_q.size()), cv_t'(0));
        check("done_count", cv_t'(done_cnt - base), cv_t'(1));
    endtask

    initial begin
        int n, addr;
        reset = 1'b1; start = 1'b0; start_addr = '0; len = '0; ready_mode = 1;
        re_cnt = 0; hs_cnt = 0; done_cnt = 0; first_busy_cyc = -1;
        prev_stall = 1'b0; prev_word = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        tick(3);
        check("rst_busy", cv_t'(busy), cv_t'(0));
        check("rst_done", cv_t'(done), cv_t'(0));
        check("rst_ram_re", cv_t'(ram_re), cv_t'(0));
        check("rst_ram_ra", cv_t'(ram_ra), cv_t'(0));
        check("rst_valid", cv_t'(out_valid), cv_t'(0));
        check("rst_last", cv_t'(out_last), cv_t'(0));
        check("rst_data", cv_t'(out_data), cv_t'(0));
        reset = 1'b0;
        tick(2);

        // Basic transfer timing with a free-running sink.
        launch(10, 4);
        wait_done(60);
        post_checks();
        check("t1_first_busy", cv_t'(first_busy_cyc), cv_t'(t0 + 1));
        check("t1_first_re", cv_t'(first_re_cyc), cv_t'(t0 + 1));
        check("t1_re_count", cv_t'(re_cnt), cv_t'(4));
        check("t1_first_valid", cv_t'(first_valid_cyc), cv_t'(t0 + 3));
        check("t1_last_hs", cv_t'(last_hs_cyc), cv_t'(t0 + 6));
        check("t1_done_cyc", cv_t'(done_cyc), cv_t'(t0 + 7));

        // Address wrap at the top of the RAM.
        launch(DEPTH - 2, 4);
        wait_done(60);
        post_checks();

        // Long stall: only the credit window may be issued.
        ready_mode = 0;
        launch(100, 16);
        tick(20);
        check("stall_re_count", cv_t'(re_cnt), cv_t'(4));
        check("stall_no_hs", cv_t'(hs_cnt), cv_t'(0));
        ready_mode = 1;
        wait_done(100);
        post_checks();
        check("stall_hs_total", cv_t'(hs_cnt), cv_t'(16));

        // Zero-length request.
        launch(5, 0);
        wait_done(20);
        post_checks();
        check("len0_done_cyc", cv_t'(done_cyc), cv_t'(t0 + 1));
        check("len0_no_re", cv_t'(re_cnt), cv_t'(0));
        check("len0_no_valid", cv_t'(valid_seen), cv_t'(0));
        check("len0_no_busy", cv_t'(first_busy_cyc), cv_t'(-1));

        // Reset in the middle of a transfer.
        launch(200, 8);
        for (int i = 0; i < 40 && hs_cnt < 3; i++) tick(1);
        check("mid_hs_reached", cv_t'(hs_cnt >= 3), cv_t'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_busy", cv_t'(busy), cv_t'(0));
        check("mid_rst_re", cv_t'(ram_re), cv_t'(0));
        check("mid_rst_ra", cv_t'(ram_ra), cv_t'(0));
        check("mid_rst_valid", cv_t'(out_valid), cv_t'(0));
        check("mid_rst_last", cv_t'(out_last), cv_t'(0));
        check("mid_rst_data", cv_t'(out_data), cv_t'(0));
        exp_q.delete();
        exp_ra_q.delete();
        base = done_cnt;
        tick(2);
        reset = 1'b0;
        tick(10);
        check("mid_rst_no_done", cv_t'(done_cnt - base), cv_t'(0));
        launch(300, 2);
        wait_done(40);
        post_checks();
        check("post_rst_words", cv_t'(hs_cnt), cv_t'(2));

        // A second start while busy must be ignored.
        launch(40, 5);
        check("busy_at_2nd_start", cv_t'(busy), cv_t'(1));
        start = 1'b1; start_addr = AW'(1000); len = LW'(3);
        tick(1);
        start = 1'b0;
        wait_done(60);
        tick(10);
        post_checks();
        check("ignored_hs_total", cv_t'(hs_cnt), cv_t'(5));

        // Random content, addresses, lengths and backpressure.
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        ready_mode = 2;
        for (int it = 0; it < 25; it++) begin
            addr = (it % 4 == 0) ? int'(DEPTH) - 1 - int'($urandom_range(0, 5))
                                 : int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(0, 40));
            launch(addr, n);
            wait_done(8 * n + 100);
            post_checks();
            tick(int'($urandom_range(0, 3)));
        end

        // Full-depth transfer covering every address once.
        launch(1234, DEPTH);
        wait_done(8 * DEPTH + 100);
        post_checks();
        check("full_hs_total", cv_t'(hs_cnt), cv_t'(DEPTH));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
